// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: round constants, word-packed state/block types,
// engine FSM encoding and the FIPS 180-4 logical operators.
package sha_pkg;

    typedef logic [255:0] state_t;
    typedef logic [511:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } fsm_e;

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message-schedule sigmas (lower-case s0/s1)
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Compression sigmas (upper-case S0/S1)
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha_round.sv
// One combinational SHA-256 round: working state a..h (a in the low word)
// plus W[t] and K[t] in, next working state out.
module sha_round
    import sha_pkg::*;
(
    input  state_t      state_in,
    input  logic [31:0] w,
    input  logic [31:0] k,
    output state_t      state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {h, g, f, e, d, c, b, a} = state_in;

    assign t1 = h + bsig1(e) + ch(e, f, g) + k + w;
    assign t2 = bsig0(a) + maj(a, b, c);

    assign state_out = {g, f, e, d + t1, c, b, a, t1 + t2};

endmodule

// File: rtl/sha_round_engine.sv
// Iterative SHA-256 compression engine evaluating RPC rounds per clock, with a
// rolling 16-word schedule window and a valid/ready handshake on each side.
module sha_round_engine
    import sha_pkg::*;
#(
    parameter int RPC    = 2,
    parameter int ADD_IV = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic [255:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest_out,
    output logic         busy
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
        $error("sha_round_engine: RPC must be 1, 2, 4 or 8");
    end

    fsm_e        st;
    logic [5:0]  cnt;
    logic [5:0]  cnt_next;
    state_t      work;
    state_t      iv;
    state_t      digest;
    state_t      sum;
    state_t      round_out;
    logic [31:0] win [16];
    logic [31:0] ext [16+RPC];

    // Window extended by the RPC words that replace the ones consumed this cycle
    always_comb begin
        for (int i = 0; i < 16 + RPC; i++) begin
            ext[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            ext[i] = win[i];
        end
        for (int j = 0; j < RPC; j++) begin
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        end
    end

    for (genvar i = 0; i < RPC; i++) begin : g_round
        state_t     st_i;
        state_t     st_o;
        logic [5:0] k_idx;

        if (i == 0) begin : g_first
            assign st_i = work;
        end else begin : g_next
            assign st_i = g_round[i-1].st_o;
        end

        assign k_idx = cnt + 6'(i);

        sha_round u_round (
            .state_in  (st_i),
            .w         (win[i]),
            .k         (K_TABLE[k_idx]),
            .state_out (st_o)
        );
    end

    assign round_out = g_round[RPC-1].st_o;
    assign cnt_next  = cnt + 6'(RPC);

    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[32*i +: 32] = iv[32*i +: 32] + work[32*i +: 32];
        end
    end

    // The counter wrapping back to zero marks the cycle that ran round 63
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= ST_IDLE;
            cnt    <= '0;
            work   <= '0;
            iv     <= '0;
            digest <= '0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (st)
                ST_IDLE: begin
                    if (in_valid) begin
                        work <= state_in;
                        iv   <= state_in;
                        cnt  <= '0;
                        for (int i = 0; i < 16; i++) begin
                            win[i] <= block_in[32*i +: 32];
                        end
                        st <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work <= round_out;
                    cnt  <= cnt_next;
                    for (int i = 0; i < 16; i++) begin
                        win[i] <= ext[i+RPC];
                    end
                    if (cnt_next == 6'd0) begin
                        st <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    digest <= (ADD_IV != 0) ? sum : work;
                    st     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        st <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (st == ST_IDLE);
    assign out_valid  = (st == ST_DONE);
    assign busy       = (st == ST_RUN) || (st == ST_ADD);
    assign digest_out = digest;

endmodule

// File: tb/tb_sha_round_engine.sv
// Drives five engine configurations in lockstep and compares every digest
// against a whole-message SHA-256 compression model and published vectors.
module tb_sha_round_engine;

    localparam int NDUT = 5;
    localparam int RPCV [NDUT] = '{1, 2, 4, 8, 2};
    localparam int ADDV [NDUT] = '{1, 1, 1, 1, 0};

    localparam logic [31:0] KM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic [511:0]       block_in = '0;
    logic [255:0]       state_in = '0;
    logic [NDUT-1:0]    ir, ov, bz;
    logic [255:0]       dg [NDUT];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sha_round_engine #(.RPC(RPCV[g]), .ADD_IV(ADDV[g])) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (ir[g]),
            .block_in   (block_in),
            .state_in   (state_in),
            .out_valid  (ov[g]),
            .out_ready  (out_ready),
            .digest_out (dg[g]),
            .busy       (bz[g])
        );
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full compression: expand all 64 schedule words first, then run 64 rounds
    function automatic logic [255:0] sha_model(input logic [255:0] iv, input logic [511:0] blk, input bit add);
        logic [31:0]  w [64];
        logic [31:0]  s [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) s[i] = iv[32*i +: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KM[t] + w[t];
            t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            for (int i = 7; i > 0; i--) s[i] = s[i-1];
            s[4] = s[4] + t1;
            s[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[32*i +: 32] = add ? s[i] + iv[32*i +: 32] : s[i];
        return r;
    endfunction

    // Published digests are written h0-first; the engine packs h0 in the low word
    function automatic logic [255:0] rev8(input logic [255:0] be);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = be[255-32*i -: 32];
        return r;
    endfunction

    function automatic logic [255:0] sub8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] - y[32*i +: 32];
        return r;
    endfunction

    task automatic run_block(input logic [511:0] blk, input logic [255:0] iv, input string tag);
        logic [255:0] exp [NDUT];
        int           lat [NDUT];
        int           nseen;
        for (int d = 0; d < NDUT; d++) begin
            exp[d] = sha_model(iv, blk, ADDV[d] != 0);
            lat[d] = -1;
        end
        chk({tag, "_in_ready"}, 256'(ir), 256'(5'h1f));
        block_in = blk;
        state_in = iv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 256'(bz), 256'(5'h1f));
        nseen = 0;
        for (int n = 1; n <= 80 && nseen < NDUT; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < NDUT; d++) begin
                if (lat[d] < 0 && ov[d]) begin
                    lat[d] = n;
                    nseen++;
                    chk($sformatf("%s_digest%0d", tag, d), dg[d], exp[d]);
                end
            end
        end
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("%s_latency%0d", tag, d), lat[d], 64 / RPCV[d] + 1);
        @(posedge clk); #1;
    endtask

    logic [255:0] std_iv, abc_dig, empty_dig, two_dig, mid_dig;
    logic [511:0] abc_blk, empty_blk, blk1, blk2, rblk;
    logic [255:0] riv;
    logic [31:0]  m1 [14] = '{
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
        32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071
    };

    initial begin
        std_iv    = rev8(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);
        abc_dig   = rev8(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
        empty_dig = rev8(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
        two_dig   = rev8(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
        abc_blk   = '0;
        abc_blk[31:0]    = 32'h61626380;
        abc_blk[511:480] = 32'h00000018;
        empty_blk = '0;
        empty_blk[31:0]  = 32'h80000000;
        blk1 = '0;
        for (int i = 0; i < 14; i++) blk1[32*i +: 32] = m1[i];
        blk1[479:448] = 32'h80000000;
        blk2 = '0;
        blk2[511:480] = 32'h000001c0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", 256'(ir), 256'(5'h1f));
        chk("reset_out_valid", 256'(ov), 256'(0));
        chk("reset_busy", 256'(bz), 256'(0));
        for (int d = 0; d < NDUT; d++) chk($sformatf("reset_digest%0d", d), dg[d], 256'(0));

        run_block(abc_blk, std_iv, "abc");
        for (int d = 0; d < 4; d++) chk($sformatf("abc_known%0d", d), dg[d], abc_dig);
        chk("abc_raw_known", dg[4], sub8(abc_dig, std_iv));

        run_block(empty_blk, std_iv, "empty");
        for (int d = 0; d < 4; d++) chk($sformatf("empty_known%0d", d), dg[d], empty_dig);

        run_block(blk1, std_iv, "two_a");
        mid_dig = sha_model(std_iv, blk1, 1'b1);
        run_block(blk2, mid_dig, "two_b");
        for (int d = 0; d < 4; d++) chk($sformatf("two_known%0d", d), dg[d], two_dig);

        // Consumer stalls: results must hold while stray blocks are offered
        out_ready = 1'b0;
        run_block(abc_blk, std_iv, "stall");
        for (int c = 0; c < 10; c++) begin
            rblk = {16{$urandom()}};
            block_in = rblk;
            state_in = {8{$urandom()}};
            in_valid = c[0];
            @(posedge clk); #1;
            chk($sformatf("stall_out_valid%0d", c), 256'(ov), 256'(5'h1f));
            chk($sformatf("stall_in_ready%0d", c), 256'(ir), 256'(0));
            chk($sformatf("stall_busy%0d", c), 256'(bz), 256'(0));
            chk($sformatf("stall_digest%0d", c), dg[0], abc_dig);
            chk($sformatf("stall_raw%0d", c), dg[4], sub8(abc_dig, std_iv));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 256'(ir), 256'(5'h1f));
        chk("release_out_valid", 256'(ov), 256'(0));
        for (int d = 0; d < 4; d++) chk($sformatf("release_hold%0d", d), dg[d], abc_dig);

        // Abort mid-run, then the first edge after reset takes a fresh block
        block_in = empty_blk;
        state_in = std_iv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", 256'(ov), 256'(0));
        chk("abort_in_ready", 256'(ir), 256'(5'h1f));
        chk("abort_busy", 256'(bz), 256'(0));
        for (int d = 0; d < NDUT; d++) chk($sformatf("abort_digest%0d", d), dg[d], 256'(0));
        rst = 1'b0;
        run_block(abc_blk, std_iv, "post_abort");
        for (int d = 0; d < 4; d++) chk($sformatf("post_abort_known%0d", d), dg[d], abc_dig);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) rblk[32*i +: 32] = $urandom();
            for (int i = 0; i < 8; i++) riv[32*i +: 32] = $urandom();
            run_block(rblk, riv, $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
